// File: rtl/mixcolumns_iter.sv
// mixcolumns_iter: iterative AES MixColumns, COLS_PER_CYCLE columns per clock over valid/ready
module mixcolumns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int N = COLS_PER_CYCLE;
  if (N != 1 && N != 2 && N != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [127:0] st, st_step;
  logic load, last;
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  // column c sits at bit offset (3-c)*32, i.e. {~c, 5'b0}; N shared datapaths pick columns cnt..cnt+N-1
  always_comb begin
    st_step = st;
    for (int k = 0; k < N; k++)
      st_step[{~(cnt + 2'(k)), 5'd0} +: 32] = mix(st[{~(cnt + 2'(k)), 5'd0} +: 32]);
  end
  assign last      = cnt == 2'(4 - N);
  assign out_valid = state == DONE;
  assign out_data  = st;
  assign busy      = state == BUSY;
  // handshake and next-state decode; a DONE block hands off and reloads in the same cycle
  always_comb begin
    in_ready = !reset && (state == IDLE || (state == DONE && out_ready));
    load     = in_valid && in_ready;
    state_nx = load ? BUSY
             : (state == BUSY && last) ? DONE
             : (state == DONE && out_ready) ? IDLE
             : state;
  end
  // state register, column counter and in-place transform of the block
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
      st    <= 128'd0;
    end else begin
      state <= state_nx;
      if (load) begin
        st  <= in_data;
        cnt <= 2'd0;
      end else if (state == BUSY) begin
        st  <= st_step;
        cnt <= cnt + 2'(N);
      end
    end
  end
endmodule

// File: tb/tb_mixcolumns_iter.sv
// tb_mixcolumns_iter: directed checks of mixcolumns_iter for 1, 2 and 4 columns per cycle
module tb_mixcolumns_iter;
  logic clk = 1'b0;
  logic reset, in_valid, out_ready;
  logic [127:0] in_data;
  logic ir1, ov1, b1, ir2, ov2, b2, ir4, ov4, b4;
  logic [127:0] od1, od2, od4;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mixcolumns_iter #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(b1));
  mixcolumns_iter #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .busy(b2));
  mixcolumns_iter #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(b4));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] m2(input logic [7:0] x);
    return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
  endfunction
  function automatic logic [7:0] m3(input logic [7:0] x);
    return m2(x) ^ x;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 4; b++) a[b] = s[127 - 32*c - 8*b -: 8];
      r[127 - 32*c -: 32] = {m2(a[0]) ^ m3(a[1]) ^ a[2] ^ a[3], a[0] ^ m2(a[1]) ^ m3(a[2]) ^ a[3],
                             a[0] ^ a[1] ^ m2(a[2]) ^ m3(a[3]), m3(a[0]) ^ a[1] ^ a[2] ^ m2(a[3])};
    end
    return r;
  endfunction
  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] exp);
    int l1, l2, l4;
    logic [127:0] d1, d2, d4;
    l1 = 0; l2 = 0; l4 = 0; d1 = '0; d2 = '0; d4 = '0;
    in_data = d; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      in_valid = 1'b0;
      if (l1 == 0 && ov1) begin l1 = i; d1 = od1; end
      if (l2 == 0 && ov2) begin l2 = i; d2 = od2; end
      if (l4 == 0 && ov4) begin l4 = i; d4 = od4; end
    end
    chk({tag, " data c1"}, d1, exp);
    chk({tag, " data c2"}, d2, exp);
    chk({tag, " data c4"}, d4, exp);
    chk({tag, " latency c1"}, 128'(l1), 128'd5);
    chk({tag, " latency c2"}, 128'(l2), 128'd3);
    chk({tag, " latency c4"}, 128'(l4), 128'd2);
  endtask
  initial begin
    logic [127:0] va, vb, sv [4];
    int k, r, last_t;
    logic pre, seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    chk("in_ready in reset", 128'(ir1), 128'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("reset out_valid", 128'(ov1), 128'd0);
    chk("reset out_data", od1, 128'd0);
    chk("reset busy", 128'(b1), 128'd0);
    chk("reset in_ready", 128'(ir1), 128'd1);
    run_block("fips", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    run_block("fips2", 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6);
    run_block("zero", 128'd0, 128'd0);
    run_block("ones", {128{1'b1}}, {128{1'b1}});
    for (int i = 0; i < 6; i++) begin
      va = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block("rand", va, model(va));
    end
    va = 128'h0123456789abcdef_fedcba9876543210;
    vb = 128'h00112233_44556677_8899aabb_ccddeeff;
    out_ready = 1'b0; in_data = va; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = ov1; end
    chk("bp valid rises", 128'(ov1), 128'd1);
    chk("bp first data", od1, model(va));
    in_data = vb; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("bp data held", od1, model(va));
      chk("bp valid held", 128'(ov1), 128'd1);
      chk("bp in_ready low", 128'(ir1), 128'd0);
      chk("bp not accepted", 128'(b1), 128'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp in_ready with out_ready", 128'(ir1), 128'd1);
    tick();
    chk("bp busy after b2b", 128'(b1), 128'd1);
    chk("bp valid dropped", 128'(ov1), 128'd0);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = ov1; end
    chk("bp second data", od1, model(vb));
    idle(10);
    for (int i = 0; i < 4; i++) sv[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_data = sv[0]; in_valid = 1'b1; out_ready = 1'b1;
    k = 0; r = 0; last_t = 0;
    for (int t = 1; t <= 40 && r < 4; t++) begin
      pre = ir1 && in_valid;
      tick();
      if (pre) begin
        k++;
        if (k < 4) in_data = sv[k];
        else in_valid = 1'b0;
      end
      if (ov1) begin
        chk("stream data", od1, model(sv[r]));
        if (r > 0) chk("stream gap", 128'(t - last_t), 128'd5);
        last_t = t;
        r++;
      end
    end
    chk("stream count", 128'(r), 128'd4);
    idle(10);
    va = 128'hcafef00d_deadbeef_13579bdf_2468ace0;
    out_ready = 1'b0; in_data = va; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid = (i % 2) == 0;
      tick();
    end
    in_valid = 1'b0;
    chk("toggle valid", 128'(ov1), 128'd1);
    chk("toggle data", od1, model(va));
    idle(10);
    in_data = 128'h11111111_22222222_33333333_44444444; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid busy", 128'(b1), 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst out_valid", 128'(ov1), 128'd0);
    chk("midrst out_data", od1, 128'd0);
    chk("midrst busy", 128'(b1), 128'd0);
    chk("midrst in_ready", 128'(ir1), 128'd1);
    vb = 128'h5a5a5a5a_a5a5a5a5_00ff00ff_ff00ff00;
    run_block("post reset", vb, model(vb));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
